// File: rtl/button_events.sv
// Front-panel button conditioning: synchronize, debounce and turn four active-low
// buttons into held levels and one-cycle press events, with auto-repeat on PLUS/MINUS.
module button_events #(
  parameter int DEB_CNT = 360000,
  parameter int RPT_DLY = 18000000,
  parameter int RPT_PER = 3600000
) (
  input  logic       CLK36,
  input  logic       RST,
  input  logic       MENU,
  input  logic       SET,
  input  logic       PLUS,
  input  logic       MINUS,
  output logic [3:0] HELD,
  output logic [3:0] EVT
);

  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int DW      = $clog2(DEB_CNT + 1);
  localparam int RW      = $clog2(RPT_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [3:0] w_pin;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_raw;
  logic [3:0] w_toggle;
  logic [3:0] w_held_nxt;
  logic [3:0] w_press;
  logic [1:0] w_rpt_pulse;
  logic       w_dual;
  logic [3:0] r_held;
  logic [3:0] r_evt;

  assign w_pin = {MENU, SET, PLUS, MINUS};

  // Two-flop synchronizer; reset parks it at the released (high) pin level.
  always_ff @(posedge CLK36) begin
    if (RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = ~r_sync2;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic [DW-1:0] r_deb_cnt;

    // Counter measures how long raw has disagreed with the held level.
    assign w_toggle[g] = (w_raw[g] != r_held[g]) && (r_deb_cnt == DEB_LAST);

    always_ff @(posedge CLK36) begin
      if (RST) begin
        r_deb_cnt <= '0;
      end else if (w_toggle[g] || (w_raw[g] == r_held[g])) begin
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  assign w_held_nxt = r_held ^ w_toggle;
  assign w_press    = w_toggle & ~r_held;
  // Holding PLUS and MINUS together suppresses repeating on both.
  assign w_dual     = w_held_nxt[1] & w_held_nxt[0];

  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_t    r_state;
    rpt_state_t    w_state_nxt;
    logic [RW-1:0] r_rpt_cnt;
    logic [RW-1:0] w_rpt_cnt_nxt;
    logic          w_pulse;

    always_ff @(posedge CLK36) begin
      if (RST) begin
        r_state   <= ST_IDLE;
        r_rpt_cnt <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_rpt_cnt <= w_rpt_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_rpt_cnt_nxt = r_rpt_cnt;
      w_pulse       = 1'b0;
      if (w_dual) begin
        w_state_nxt   = ST_IDLE;
        w_rpt_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_rpt_cnt_nxt = '0;
            if (w_press[g]) begin
              w_state_nxt = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (!w_held_nxt[g]) begin
              w_state_nxt   = ST_IDLE;
              w_rpt_cnt_nxt = '0;
            end else if (r_rpt_cnt == DLY_LAST) begin
              w_pulse       = 1'b1;
              w_state_nxt   = ST_REPEAT;
              w_rpt_cnt_nxt = '0;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (!w_held_nxt[g]) begin
              w_state_nxt   = ST_IDLE;
              w_rpt_cnt_nxt = '0;
            end else if (r_rpt_cnt == PER_LAST) begin
              w_pulse       = 1'b1;
              w_rpt_cnt_nxt = '0;
            end else begin
              w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
            end
          end
          default: begin
            w_state_nxt   = ST_IDLE;
            w_rpt_cnt_nxt = '0;
          end
        endcase
      end
    end

    assign w_rpt_pulse[g] = w_pulse;
  end

  // Output register: held level plus press/repeat pulses.
  always_ff @(posedge CLK36) begin
    if (RST) begin
      r_held <= '0;
      r_evt  <= '0;
    end else begin
      r_held <= w_held_nxt;
      r_evt  <= w_press | {2'b00, w_rpt_pulse};
    end
  end

  assign HELD = r_held;
  assign EVT  = r_evt;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with short debounce/repeat times.
module tb_button_events;

  logic       CLK36;
  logic       RST;
  logic       MENU;
  logic       SET;
  logic       PLUS;
  logic       MINUS;
  logic [3:0] HELD;
  logic [3:0] EVT;

  int n_cmp;
  int n_err;

  button_events #(
    .DEB_CNT(4),
    .RPT_DLY(20),
    .RPT_PER(8)
  ) dut (
    .CLK36(CLK36),
    .RST  (RST),
    .MENU (MENU),
    .SET  (SET),
    .PLUS (PLUS),
    .MINUS(MINUS),
    .HELD (HELD),
    .EVT  (EVT)
  );

  initial CLK36 = 1'b0;
  always #5 CLK36 = ~CLK36;

  // Advance one clock edge and settle; outputs then reflect that edge.
  task automatic step();
    @(posedge CLK36);
    #1;
  endtask

  task automatic idle_gap(input int n);
    MENU = 1'b1; SET = 1'b1; PLUS = 1'b1; MINUS = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    MENU = 1'b1; SET = 1'b1; PLUS = 1'b1; MINUS = 1'b1;
    step();
    step();
    n_cmp++;
    if (HELD !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_held HELD=%b expected=%b", HELD, 4'b0000);
    end
    n_cmp++;
    if (EVT !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_evt EVT=%b expected=%b", EVT, 4'b0000);
    end
    RST = 1'b0;
    idle_gap(4);
  endtask

  task automatic test_glitch();
    MENU = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3) MENU = 1'b1;
      n_cmp++;
      if (HELD !== 4'b0000) begin
        n_err++;
        $display("FAIL glitch_held k=%0d HELD=%b expected=%b", k, HELD, 4'b0000);
      end
      n_cmp++;
      if (EVT !== 4'b0000) begin
        n_err++;
        $display("FAIL glitch_evt k=%0d EVT=%b expected=%b", k, EVT, 4'b0000);
      end
    end
    idle_gap(4);
  endtask

  task automatic test_single_press();
    logic [3:0] eh;
    logic [3:0] ee;
    SET = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      eh = (k >= 6) ? 4'b0100 : 4'b0000;
      ee = (k == 6) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (HELD !== eh) begin
        n_err++;
        $display("FAIL set_press_held k=%0d HELD=%b expected=%b", k, HELD, eh);
      end
      n_cmp++;
      if (EVT !== ee) begin
        n_err++;
        $display("FAIL set_press_evt k=%0d EVT=%b expected=%b", k, EVT, ee);
      end
    end
    SET = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      eh = (k < 6) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (HELD !== eh) begin
        n_err++;
        $display("FAIL set_release_held k=%0d HELD=%b expected=%b", k, HELD, eh);
      end
      n_cmp++;
      if (EVT !== 4'b0000) begin
        n_err++;
        $display("FAIL set_release_evt k=%0d EVT=%b expected=%b", k, EVT, 4'b0000);
      end
    end
    idle_gap(4);
  endtask

  task automatic test_repeat();
    logic [3:0] eh;
    logic [3:0] ee;
    PLUS = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (k == 60) PLUS = 1'b1;
      eh = (k >= 6 && k < 66) ? 4'b0010 : 4'b0000;
      ee = ((k == 6) || (k >= 26 && k < 66 && ((k - 26) % 8) == 0)) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (HELD !== eh) begin
        n_err++;
        $display("FAIL plus_repeat_held k=%0d HELD=%b expected=%b", k, HELD, eh);
      end
      n_cmp++;
      if (EVT !== ee) begin
        n_err++;
        $display("FAIL plus_repeat_evt k=%0d EVT=%b expected=%b", k, EVT, ee);
      end
    end
    idle_gap(4);
  endtask

  task automatic test_simultaneous();
    logic [3:0] eh;
    logic [3:0] ee;
    MENU = 1'b0; SET = 1'b0; PLUS = 1'b0; MINUS = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 30) begin
        MENU = 1'b1; SET = 1'b1; PLUS = 1'b1; MINUS = 1'b1;
      end
      eh = (k >= 6 && k < 36) ? 4'b1111 : 4'b0000;
      ee = (k == 6) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (HELD !== eh) begin
        n_err++;
        $display("FAIL simul_held k=%0d HELD=%b expected=%b", k, HELD, eh);
      end
      n_cmp++;
      if (EVT !== ee) begin
        n_err++;
        $display("FAIL simul_evt k=%0d EVT=%b expected=%b", k, EVT, ee);
      end
    end
    idle_gap(4);
  endtask

  task automatic test_dual_hold();
    logic [3:0] eh;
    logic [3:0] ee;
    PLUS = 1'b0;
    for (int k = 1; k <= 155; k++) begin
      step();
      if (k == 2)   MINUS = 1'b0;
      if (k == 62)  MINUS = 1'b1;
      if (k == 110) PLUS  = 1'b1;
      if (k == 125) PLUS  = 1'b0;
      eh = 4'b0000;
      eh[1] = ((k >= 6 && k < 116) || k >= 131);
      eh[0] = (k >= 8 && k < 68);
      ee = 4'b0000;
      if (k == 6 || k == 131 || k == 151) ee = 4'b0010;
      if (k == 8) ee = 4'b0001;
      n_cmp++;
      if (HELD !== eh) begin
        n_err++;
        $display("FAIL dual_held k=%0d HELD=%b expected=%b", k, HELD, eh);
      end
      n_cmp++;
      if (EVT !== ee) begin
        n_err++;
        $display("FAIL dual_evt k=%0d EVT=%b expected=%b", k, EVT, ee);
      end
    end
    idle_gap(20);
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] eh;
    logic [3:0] ee;
    PLUS = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 30) RST = 1'b1;
      if (k == 31) RST = 1'b0;
      eh = ((k >= 6 && k < 31) || k >= 37) ? 4'b0010 : 4'b0000;
      ee = (k == 6 || k == 26 || k == 37 || k == 57) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (HELD !== eh) begin
        n_err++;
        $display("FAIL rst_mid_held k=%0d HELD=%b expected=%b", k, HELD, eh);
      end
      n_cmp++;
      if (EVT !== ee) begin
        n_err++;
        $display("FAIL rst_mid_evt k=%0d EVT=%b expected=%b", k, EVT, ee);
      end
    end
    idle_gap(20);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    MENU = 1'b1; SET = 1'b1; PLUS = 1'b1; MINUS = 1'b1;
    test_reset();
    test_glitch();
    test_single_press();
    test_repeat();
    test_simultaneous();
    test_dual_hold();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
